// File: rtl/fpu_sched_pkg.sv
// Types and helpers shared by the FPU operation schedulers.
package fpu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } sched_state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_addsub_scheduler_rr_arbiter.sv
// Combinational round-robin grant: the first active request after last_i, with wrap-around.
module rr_arbiter
  import fpu_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          any_o
);

  logic [IW-1:0] sel;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    sel      = '0;
    for (int k = 1; k <= N; k++) begin
      sel = IW'((int'(last_i) + k) % N);
      if (!any_o && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        gnt_id_o   = sel;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_scheduler.sv
// Shares one float add/sub datapath between NUM_REQ requesters, one operation in flight.
//   state | meaning
//   IDLE  | arbitrate; latch operands of the granted requester
//   LOAD  | hold fu_load with stable operands for LOAD_CYCLES cycles
//   WAIT  | wait for fu_valid under watchdog; first cycle's valid is stale
//   RESP  | one-cycle result strobe tagged with requester id
module fpu_addsub_scheduler
  import fpu_sched_pkg::*;
#(
  parameter  int PRECISION   = 32,
  parameter  int NUM_REQ     = 4,
  parameter  int LOAD_CYCLES = 2,
  parameter  int TIMEOUT     = 64,
  localparam int ID_W        = id_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*PRECISION-1:0]   req_a,
  input  logic [NUM_REQ*PRECISION-1:0]   req_b,
  input  logic [NUM_REQ-1:0]             req_op,
  output logic                           resp_valid,
  output logic [ID_W-1:0]                resp_id,
  output logic [PRECISION-1:0]           resp_data,
  output logic                           resp_err,
  output logic                           busy,
  output logic [PRECISION-1:0]           fu_inA,
  output logic [PRECISION-1:0]           fu_inB,
  output logic                           fu_op,
  output logic                           fu_load,
  input  logic [PRECISION-1:0]           fu_out,
  input  logic                           fu_valid
);

  localparam int LC_W = id_w(LOAD_CYCLES);
  localparam int WD_W = id_w(TIMEOUT);

  sched_state_e         state_q;
  logic [ID_W-1:0]      last_grant_q;
  logic [ID_W-1:0]      id_q;
  logic [LC_W-1:0]      load_cnt_q;
  logic [WD_W-1:0]      wd_cnt_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic [ID_W-1:0]      resp_id_q;
  logic [PRECISION-1:0] resp_data_q;
  logic [PRECISION-1:0] fu_inA_q;
  logic [PRECISION-1:0] fu_inB_q;
  logic                 fu_op_q;
  logic                 fu_load_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_id;
  logic                 gnt_any;
  logic                 xfer;
  logic [PRECISION-1:0] a_slice [NUM_REQ];
  logic [PRECISION-1:0] b_slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign a_slice[g] = req_a[g*PRECISION +: PRECISION];
    assign b_slice[g] = req_b[g*PRECISION +: PRECISION];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i    (req_valid),
    .last_i   (last_grant_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (gnt_any)
  );

  // Ready is combinational so a request can transfer in its first IDLE cycle; held low in reset.
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign xfer      = (state_q == IDLE) && gnt_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      load_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      fu_inA_q     <= '0;
      fu_inB_q     <= '0;
      fu_op_q      <= OP_ADD;
      fu_load_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            fu_inA_q     <= a_slice[gnt_id];
            fu_inB_q     <= b_slice[gnt_id];
            fu_op_q      <= req_op[gnt_id];
            id_q         <= gnt_id;
            last_grant_q <= gnt_id;
            load_cnt_q   <= '0;
            fu_load_q    <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          if (load_cnt_q == LC_W'(LOAD_CYCLES - 1)) begin
            fu_load_q <= 1'b0;
            wd_cnt_q  <= '0;
            state_q   <= WAIT;
          end else begin
            load_cnt_q <= load_cnt_q + LC_W'(1);
          end
        end
        WAIT: begin
          wd_cnt_q <= wd_cnt_q + WD_W'(1);
          // Valid in the first WAIT cycle still reflects the previous operation.
          if (fu_valid && wd_cnt_q != '0) begin
            resp_data_q  <= fu_out;
            resp_err_q   <= 1'b0;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign fu_inA     = fu_inA_q;
  assign fu_inB     = fu_inB_q;
  assign fu_op      = fu_op_q;
  assign fu_load    = fu_load_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_addsub_scheduler.sv
// Bench for fpu_addsub_scheduler: integer-valued float datapath model plus a cycle-level scoreboard.
module tb_fpu_addsub_scheduler;
  import fpu_sched_pkg::*;

  localparam int NR = 4;
  localparam int P  = 32;
  localparam int LC = 2;
  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NR-1:0]   req_valid, req_ready, req_op;
  logic [NR*P-1:0] req_a, req_b;
  logic            resp_valid, resp_err, busy;
  logic [1:0]      resp_id;
  logic [P-1:0]    resp_data, fu_inA, fu_inB;
  logic [P-1:0]    fu_out   = '0;
  logic            fu_valid = 1'b0;
  logic            fu_op, fu_load;

  fpu_addsub_scheduler #(.PRECISION(P), .NUM_REQ(NR), .LOAD_CYCLES(LC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .fu_inA(fu_inA), .fu_inB(fu_inB), .fu_op(fu_op), .fu_load(fu_load),
    .fu_out(fu_out), .fu_valid(fu_valid)
  );

  int total = 0;
  int bad   = 0;

  int   ia [NR];
  int   ib [NR];
  logic opv[NR];
  int   fu_delay;
  bit   stale_en;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          rcyc;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  bit          m_busy = 1'b0;
  int          m_last = NR - 1;
  int          ld_left = 0;
  int          cyc = 0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rid = '0;
  logic        last_err = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_op = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] int2f(input int v);
    int m;
    int p;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int k = 0; k < 24; k++) if (m >= (1 << k)) p = k;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(m << (23 - p));
    return r;
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    int m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({1'b1, f[22:0]}) >> (23 - e);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [NR-1:0] rr_exp(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (last + k) % NR;
      if (v[i[1:0]]) return NR'(1) << i;
    end
    return '0;
  endfunction

  task automatic apply_ops();
    req_a  = {int2f(ia[3]), int2f(ia[2]), int2f(ia[1]), int2f(ia[0])};
    req_b  = {int2f(ib[3]), int2f(ib[2]), int2f(ib[1]), int2f(ib[0])};
    req_op = {opv[3], opv[2], opv[1], opv[0]};
  endtask

  // Datapath model: answers fu_delay WAIT cycles after load, optionally with a stale first-cycle valid.
  int          wc = 0;
  bit          pend = 1'b0;
  logic [31:0] res = '0;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0; wc = 0; fu_valid = 1'b0; fu_out = '0;
    end else if (fu_load) begin
      pend = 1'b1; wc = -1; fu_valid = 1'b0;
      res = int2f(fu_op ? f2i(fu_inA) - f2i(fu_inB) : f2i(fu_inA) + f2i(fu_inB));
    end else if (pend) begin
      wc++;
      if (wc == fu_delay) begin
        fu_valid = 1'b1; fu_out = res;
      end else if (wc == 0 && stale_en) begin
        fu_valid = 1'b1; fu_out = 32'hDEADBEEF;
      end else begin
        fu_valid = 1'b0;
        if (wc > fu_delay) pend = 1'b0;
      end
    end else begin
      fu_valid = 1'b0;
    end
  end

  // Scoreboard: predicts grants, load window and response timing from the operation rules.
  always @(negedge clk) begin
    logic [NR-1:0] er;
    logic el, ev;
    int g;
    exp_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0; m_last = NR - 1; ld_left = 0; m_rdata = '0; m_rid = '0;
    end else begin
      er = m_busy ? '0 : rr_exp(req_valid, m_last);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(m_busy));
      el = (ld_left > 0);
      chk("fu_load", 32'(fu_load), 32'(el));
      if (el) begin
        chk("fu_inA", fu_inA, m_a);
        chk("fu_inB", fu_inB, m_b);
        chk("fu_op", 32'(fu_op), 32'(m_op));
        ld_left--;
      end
      ev = (exp_q.size() > 0) && (exp_q[0].rcyc == cyc);
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      if (ev) begin
        e = exp_q.pop_front();
        m_rdata = e.data;
        m_rid = 2'(e.id);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        last_err = resp_err;
        m_busy = 1'b0;
      end else begin
        chk("resp_err_idle", 32'(resp_err), 32'd0);
      end
      chk("resp_data", resp_data, m_rdata);
      chk("resp_id", 32'(resp_id), 32'(m_rid));
      if (er != '0) begin
        g = 0;
        for (int i = 0; i < NR; i++) if (er[i]) g = i;
        e.id   = g;
        e.err  = (fu_delay > TO - 1);
        e.data = e.err ? 32'h0 : int2f(opv[g] ? ia[g] - ib[g] : ia[g] + ib[g]);
        e.rcyc = cyc + LC + 2 + ((fu_delay < TO - 1) ? fu_delay : TO - 1);
        exp_q.push_back(e);
        grant_log.push_back(g);
        m_busy = 1'b1; m_last = g; ld_left = LC;
        m_a = int2f(ia[g]); m_b = int2f(ib[g]); m_op = opv[g];
      end
    end
  end

  task automatic wait_grants(input int n);
    int k;
    k = 0;
    while (grant_log.size() < n && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk("grant_wait", 32'(grant_log.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() > 0 || m_busy) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_wait", 32'(exp_q.size() == 0 && !m_busy), 32'd1);
  endtask

  task automatic issue(input int id, input int a, input int b, input logic op);
    int n;
    ia[id] = a; ib[id] = b; opv[id] = op;
    apply_ops();
    n = grant_log.size();
    req_valid = NR'(1) << id;
    wait_grants(n + 1);
    req_valid = '0;
    wait_idle();
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_fu_load"}, 32'(fu_load), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_fu_inA"}, fu_inA, 32'd0);
    chk({tag, "_fu_inB"}, fu_inB, 32'd0);
    chk({tag, "_fu_op"}, 32'(fu_op), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [NR-1:0] mask;
    rst = 1'b1;
    req_valid = '0;
    fu_delay = 2;
    stale_en = 1'b1;
    for (int i = 0; i < NR; i++) begin
      ia[i] = 10 * (i + 1); ib[i] = i + 1; opv[i] = (i % 2 == 1);
    end
    apply_ops();
    req_valid = '1;
    @(posedge clk); #1;
    chk_all_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // All four requesting from reset: rotation 0,1,2,3,0.
    wait_grants(5);
    req_valid = '0;
    wait_idle();
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(grant_log[i]), 32'(i % NR));

    issue(0, 1, 2, OP_ADD);
    chk("add_data", resp_data, 32'h40400000);
    chk("add_id", 32'(resp_id), 32'd0);
    issue(2, 3, 1, OP_SUB);
    chk("sub_data", resp_data, 32'h40000000);
    chk("sub_id", 32'(resp_id), 32'd2);

    for (int t = 0; t < 16; t++) begin
      fu_delay = int'($urandom_range(1, 8));
      stale_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < NR; i++) begin
        ia[i] = int'($urandom_range(0, 100000));
        ib[i] = int'($urandom_range(0, 100000));
        opv[i] = 1'($urandom_range(0, 1));
      end
      apply_ops();
      mask = NR'($urandom_range(1, 15));
      n = grant_log.size();
      req_valid = mask;
      wait_grants(n + 1);
      req_valid = '0;
      wait_idle();
    end

    // Stuck datapath: watchdog response, then normal service resumes.
    fu_delay = 1000;
    stale_en = 1'b0;
    issue(1, 7, 5, OP_ADD);
    chk("timeout_err", 32'(last_err), 32'd1);
    chk("timeout_data", resp_data, 32'd0);
    fu_delay = 2;
    stale_en = 1'b1;
    issue(3, 9, 4, OP_SUB);
    chk("after_to_data", resp_data, 32'h40A00000);
    chk("after_to_err", 32'(last_err), 32'd0);

    // Valid arriving on the last watchdog cycle wins.
    fu_delay = TO - 1;
    issue(0, 6, 2, OP_ADD);
    chk("edge_err", 32'(last_err), 32'd0);
    chk("edge_data", resp_data, 32'h41000000);

    // Reset while waiting: everything clears at once, no response, arbitration restarts at 0.
    fu_delay = 1000;
    ia[1] = 11; ib[1] = 3; opv[1] = OP_ADD;
    apply_ops();
    n = grant_log.size();
    req_valid = 4'b0010;
    wait_grants(n + 1);
    req_valid = '0;
    repeat (LC + 3) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_all_reset("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    fu_delay = 2;
    ia[0] = 4; ib[0] = 4; opv[0] = OP_SUB;
    ia[2] = 5; ib[2] = 1; opv[2] = OP_ADD;
    apply_ops();
    n = grant_log.size();
    req_valid = 4'b0101;
    wait_grants(n + 1);
    req_valid = '0;
    chk("post_rst_grant", 32'(grant_log[$]), 32'd0);
    wait_idle();
    chk("post_rst_data", resp_data, 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
